// File: rtl/alu_operand_pkg.sv
// Shared forwarding-select encoding for the ID/EX operand stage.
package alu_operand_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/alu_operand_stage_forward_unit.sv
// Combinational forwarding for one source register: EX/MEM beats MEM/WB beats register file.
module forward_unit
  import alu_operand_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int ZERO_REG_FWD = 0
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [WIDTH-1:0]      regdata,
  input  logic                  exmem_RegWrite,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [WIDTH-1:0]      exmem_result,
  input  logic                  memwb_RegWrite,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [WIDTH-1:0]      memwb_result,
  output logic [1:0]            sel,
  output logic [WIDTH-1:0]      fwd
);

  logic fwd_ok;

  // Register 0 is hardwired to zero, so forwarding a write to it is normally wrong.
  assign fwd_ok = (src != '0) || (ZERO_REG_FWD != 0);

  always_comb begin
    sel = FWD_REG;
    fwd = regdata;
    if (exmem_RegWrite && (exmem_rd == src) && fwd_ok) begin
      sel = FWD_MEM;
      fwd = exmem_result;
    end else if (memwb_RegWrite && (memwb_rd == src) && fwd_ok) begin
      sel = FWD_WB;
      fwd = memwb_result;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: resolves forwarded ALU operands and store data, then registers them.
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int ZERO_REG_FWD = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ALUSrc,
  input  logic [WIDTH-1:0]      ReadData1,
  input  logic [WIDTH-1:0]      ReadData2,
  input  logic [WIDTH-1:0]      sigExt,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  exmem_RegWrite,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [WIDTH-1:0]      exmem_result,
  input  logic                  memwb_RegWrite,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [WIDTH-1:0]      memwb_result,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      opA,
  output logic [WIDTH-1:0]      opB,
  output logic [WIDTH-1:0]      storeData,
  output logic [1:0]            fwdA_sel,
  output logic [1:0]            fwdB_sel
);

  logic [1:0]       selA, selB;
  logic [WIDTH-1:0] fwdA, fwdB;
  logic [WIDTH-1:0] opB_next;

  forward_unit #(
    .WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W), .ZERO_REG_FWD(ZERO_REG_FWD)
  ) u_fwd_a (
    .src(rs), .regdata(ReadData1),
    .exmem_RegWrite(exmem_RegWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .sel(selA), .fwd(fwdA)
  );

  forward_unit #(
    .WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W), .ZERO_REG_FWD(ZERO_REG_FWD)
  ) u_fwd_b (
    .src(rt), .regdata(ReadData2),
    .exmem_RegWrite(exmem_RegWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .sel(selB), .fwd(fwdB)
  );

  assign opB_next = ALUSrc ? sigExt : fwdB;

  // Data registers load regardless of in_valid; out_valid alone qualifies them downstream.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid <= 1'b0;
      opA       <= '0;
      opB       <= '0;
      storeData <= '0;
      fwdA_sel  <= FWD_REG;
      fwdB_sel  <= FWD_REG;
    end else if (!stall) begin
      out_valid <= in_valid;
      opA       <= fwdA;
      opB       <= opB_next;
      storeData <= fwdB;
      fwdA_sel  <= selA;
      fwdB_sel  <= selB;
    end
  end

endmodule
